riscv_li_expander: RTL and testbench

RISCV_LI_EXPANDER -- requirements
Module: riscv_li_expander

---
 rtl/riscv_li_expander_if.sv | 38 +++
 rtl/riscv_li_expander.sv | 209 ++++++++++++++++++++
 tb/tb_riscv_li_expander.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_li_expander_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : riscv_li_expander_if
// Description : Handshake bundle for the load-immediate expander. Carries the
//               request channel (constant and destination register in) and
//               the instruction channel (encoded RV64I words out).
//   Request channel  : req_valid, req_ready, req_imm, req_rd
//   Instr channel    : instr_valid, instr_ready, instr, instr_last
//   master modport   : the requester / instruction consumer side
//   slave modport    : the expander side
// Revision    : 1.0 - initial release
// ============================================================================
interface riscv_li_expander_if #(
    parameter int IBUS_DATA_WIDTH = 32,
    parameter int DBUS_DATA_WIDTH = 64
);
    logic                       req_valid;
    logic                       req_ready;
    logic [DBUS_DATA_WIDTH-1:0] req_imm;
    logic [4:0]                 req_rd;

    logic                       instr_valid;
    logic                       instr_ready;
    logic [IBUS_DATA_WIDTH-1:0] instr;
    logic                       instr_last;

    modport master (
        output req_valid, req_imm, req_rd, instr_ready,
        input  req_ready, instr_valid, instr, instr_last
    );

    modport slave (
        input  req_valid, req_imm, req_rd, instr_ready,
        output req_ready, instr_valid, instr, instr_last
    );
endinterface
`default_nettype wire

// File: rtl/riscv_li_expander.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : riscv_li_expander
// Description : Expands a 64-bit "load immediate" request into the shortest
//               of three fixed RV64I sequences (1, 2 or 8 words) and streams
//               the words out one per handshake.
//   clk   : rising-edge clock for all state
//   rst   : synchronous active-high reset
//   bus   : riscv_li_expander_if.slave
//           req_valid/req_ready/req_imm/req_rd     - request channel
//           instr_valid/instr_ready/instr/instr_last - instruction channel
// Revision    : 1.0 - initial release
// ============================================================================
module riscv_li_expander #(
    parameter int IBUS_DATA_WIDTH = 32,
    parameter int DBUS_DATA_WIDTH = 64
) (
    input  wire logic          clk,
    input  wire logic          rst,
    riscv_li_expander_if.slave bus
);

    // Only the RV64I configuration is meaningful.
    if (IBUS_DATA_WIDTH != 32 || DBUS_DATA_WIDTH != 64) begin : g_bad_width
        $error("riscv_li_expander supports IBUS_DATA_WIDTH=32, DBUS_DATA_WIDTH=64 only");
    end

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_emit = 1'b1;

    localparam logic [6:0] c_op_lui   = 7'b0110111;
    localparam logic [6:0] c_op_imm   = 7'b0010011;
    localparam logic [6:0] c_op_immw  = 7'b0011011;
    localparam logic [2:0] c_f3_add   = 3'b000;
    localparam logic [2:0] c_f3_sll   = 3'b001;
    localparam logic [31:0] c_nop     = 32'h0000_0013;

    // The length register holds (sequence length - 1) so that 8 fits in
    // three bits; it is also directly the index of the final step.
    localparam logic [2:0] c_last_len1 = 3'd0;
    localparam logic [2:0] c_last_len2 = 3'd1;
    localparam logic [2:0] c_last_len8 = 3'd7;

    // ------------------------------------------------------------------
    // Instruction builders
    // ------------------------------------------------------------------
    function automatic logic [31:0] f_addi(input logic [4:0] rd, input logic [4:0] rs1,
                                           input logic [11:0] imm12);
        return {imm12, rs1, c_f3_add, rd, c_op_imm};
    endfunction

    function automatic logic [31:0] f_slli(input logic [4:0] rd, input logic [5:0] shamt);
        return {6'b000000, shamt, rd, c_f3_sll, rd, c_op_imm};
    endfunction

    // LUI/ADDIW pair for a 32-bit value. The +0x800 rounding compensates
    // for ADDIW sign-extending its 12-bit immediate; the sum wraps at 32
    // bits so 0x7FFFFFFF yields hi=0x80000, lo=0xFFF.
    function automatic logic [31:0] f_pair(input logic [4:0] rd, input logic [31:0] u,
                                           input logic sel_addiw);
        logic [31:0] v_sum;
        v_sum = u + 32'h0000_0800;
        if (sel_addiw) begin
            return {u[11:0], rd, c_f3_add, rd, c_op_immw};
        end
        return {v_sum[31:12], rd, c_op_lui};
    endfunction

    // Word at position 'step' of the sequence selected by 'last_idx'.
    function automatic logic [31:0] f_encode(input logic [63:0] imm, input logic [4:0] rd,
                                             input logic [2:0] last_idx, input logic [2:0] step);
        logic [31:0] v_word;
        v_word = c_nop;
        if (last_idx == c_last_len1) begin
            if (rd != 5'd0) begin
                v_word = f_addi(rd, 5'd0, imm[11:0]);
            end
        end else if (last_idx == c_last_len2) begin
            v_word = f_pair(rd, imm[31:0], step[0]);
        end else begin
            case (step)
                3'd0:    v_word = f_pair(rd, imm[63:32], 1'b0);
                3'd1:    v_word = f_pair(rd, imm[63:32], 1'b1);
                3'd2:    v_word = f_slli(rd, 6'd11);
                3'd3:    v_word = f_addi(rd, rd, {1'b0, imm[31:21]});
                3'd4:    v_word = f_slli(rd, 6'd11);
                3'd5:    v_word = f_addi(rd, rd, {1'b0, imm[20:10]});
                3'd6:    v_word = f_slli(rd, 6'd10);
                default: v_word = f_addi(rd, rd, {2'b00, imm[9:0]});
            endcase
        end
        return v_word;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]  r_state;
    logic [2:0]  r_step;
    logic [2:0]  r_len;
    logic [63:0] r_imm;
    logic [4:0]  r_rd;
    logic [31:0] r_instr;
    logic        r_last;

    logic [0:0]  w_state_nxt;
    logic [2:0]  w_step_nxt;
    logic [2:0]  w_len_nxt;
    logic [63:0] w_imm_nxt;
    logic [4:0]  w_rd_nxt;
    logic [31:0] w_instr_nxt;
    logic        w_last_nxt;

    logic        w_req_ready;
    logic        w_instr_valid;
    logic        w_fits12;
    logic        w_fits32;
    logic [2:0]  w_req_len;
    logic [2:0]  w_step_inc;

    // A value sign-extends from N bits when bits [63:N-1] are all equal.
    assign w_fits12 = (&bus.req_imm[63:11]) | ~(|bus.req_imm[63:11]);
    assign w_fits32 = (&bus.req_imm[63:31]) | ~(|bus.req_imm[63:31]);

    // rd==0 always collapses to a single NOP regardless of the constant.
    assign w_req_len = ((bus.req_rd == 5'd0) || w_fits12) ? c_last_len1 :
                       w_fits32                            ? c_last_len2 :
                                                             c_last_len8;

    assign w_step_inc = r_step + 3'd1;

    always_comb begin
        w_state_nxt   = r_state;
        w_step_nxt    = r_step;
        w_len_nxt     = r_len;
        w_imm_nxt     = r_imm;
        w_rd_nxt      = r_rd;
        w_instr_nxt   = r_instr;
        w_last_nxt    = r_last;
        w_req_ready   = 1'b0;
        w_instr_valid = 1'b0;

        case (r_state)
            c_st_idle: begin
                w_req_ready = 1'b1;
                if (bus.req_valid) begin
                    w_state_nxt = c_st_emit;
                    w_step_nxt  = 3'd0;
                    w_len_nxt   = w_req_len;
                    w_imm_nxt   = bus.req_imm;
                    w_rd_nxt    = bus.req_rd;
                    w_instr_nxt = f_encode(bus.req_imm, bus.req_rd, w_req_len, 3'd0);
                    w_last_nxt  = (w_req_len == c_last_len1);
                end
            end

            c_st_emit: begin
                w_instr_valid = 1'b1;
                if (bus.instr_ready) begin
                    if (r_step == r_len) begin
                        w_state_nxt = c_st_idle;
                        w_step_nxt  = 3'd0;
                        w_instr_nxt = 32'h0000_0000;
                        w_last_nxt  = 1'b0;
                    end else begin
                        w_step_nxt  = w_step_inc;
                        w_instr_nxt = f_encode(r_imm, r_rd, r_len, w_step_inc);
                        w_last_nxt  = (w_step_inc == r_len);
                    end
                end
            end

            default: begin
                w_state_nxt = c_st_idle;
                w_step_nxt  = 3'd0;
                w_instr_nxt = 32'h0000_0000;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
            r_step  <= 3'd0;
            r_len   <= 3'd0;
            r_imm   <= 64'd0;
            r_rd    <= 5'd0;
            r_instr <= 32'h0000_0000;
            r_last  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_step  <= w_step_nxt;
            r_len   <= w_len_nxt;
            r_imm   <= w_imm_nxt;
            r_rd    <= w_rd_nxt;
            r_instr <= w_instr_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign bus.req_ready   = w_req_ready;
    assign bus.instr_valid = w_instr_valid;
    assign bus.instr       = r_instr;
    assign bus.instr_last  = r_last;

endmodule
`default_nettype wire

// File: tb/tb_riscv_li_expander.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_riscv_li_expander
// Description : Scoreboard bench for riscv_li_expander. Stimulus pushes the
//               hand-computed words of each request into a queue; a monitor
//               pops and compares on every instruction handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_riscv_li_expander;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    riscv_li_expander_if #(.IBUS_DATA_WIDTH(32), .DBUS_DATA_WIDTH(64)) bus ();

    riscv_li_expander #(
        .IBUS_DATA_WIDTH(32),
        .DBUS_DATA_WIDTH(64)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_tests  = 0;
    int          n_fail   = 0;
    int          n_popped = 0;
    logic [32:0] q_exp [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [31:0] w, input logic last);
        q_exp.push_back({last, w});
    endtask

    // Monitor: every handshake must match the oldest outstanding word.
    always @(negedge clk) begin
        if (!rst && bus.instr_valid && bus.instr_ready) begin
            if (q_exp.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_word: got %h expected none", bus.instr);
            end else begin
                check("word", {31'd0, bus.instr_last, bus.instr}, {31'd0, q_exp.pop_front()});
            end
            n_popped++;
        end
    end

    // Holds req_valid until the request is taken at a rising edge.
    task automatic send(input logic [63:0] imm, input logic [4:0] rd);
        int guard;
        guard = 0;
        bus.req_valid = 1'b1;
        bus.req_imm   = imm;
        bus.req_rd    = rd;
        forever begin
            @(negedge clk);
            if (bus.req_ready) break;
            guard++;
            if (guard > 200) break;
        end
        check("accept_timeout", {63'd0, bus.req_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (q_exp.size() != 0 && guard < 500) begin
            @(posedge clk);
            guard++;
        end
        check("drain", 64'(q_exp.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pops(input int target);
        int guard;
        guard = 0;
        do begin
            @(posedge clk);
            #1;
            guard++;
        end while (n_popped < target && guard < 200);
        check("pop_wait", 64'(n_popped), 64'(target));
    endtask

    logic [31:0] seq_a [8];
    logic [31:0] seq_b [8];

    initial begin
        int base;
        seq_a = '{32'h000000B7, 32'h0010809B, 32'h00B09093, 32'h00008093,
                  32'h00B09093, 32'h00008093, 32'h00A09093, 32'h00008093};
        seq_b = '{32'h000000B7, 32'h0010809B, 32'h00B09093, 32'h00008093,
                  32'h00B09093, 32'h00308093, 32'h00A09093, 32'h00308093};

        rst             = 1'b1;
        bus.req_valid   = 1'b0;
        bus.req_imm     = 64'd0;
        bus.req_rd      = 5'd0;
        bus.instr_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_instr_valid", {63'd0, bus.instr_valid}, 64'd0);
        check("rst_instr_last",  {63'd0, bus.instr_last},  64'd0);
        check("rst_instr",       {32'd0, bus.instr},       64'd0);
        check("rst_req_ready",   {63'd0, bus.req_ready},   64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single-word latency and req_ready recovery.
        push_exp(32'h00500093, 1'b1);
        send(64'd5, 5'd1);
        check("lat_instr_valid", {63'd0, bus.instr_valid}, 64'd1);
        check("lat_req_ready",   {63'd0, bus.req_ready},   64'd0);
        check("lat_instr",       {32'd0, bus.instr},       64'h00500093);
        @(posedge clk);
        #1;
        check("post_req_ready",   {63'd0, bus.req_ready},   64'd1);
        check("post_instr_valid", {63'd0, bus.instr_valid}, 64'd0);

        // All-ones and rd==0.
        push_exp(32'hFFF00113, 1'b1);
        send(64'hFFFF_FFFF_FFFF_FFFF, 5'd2);
        push_exp(32'h00000013, 1'b1);
        send(64'h0000_0001_2345_6789, 5'd0);
        drain();

        // 12/32-bit boundaries, back-to-back with req_valid held.
        push_exp(32'h7FF00193, 1'b1);
        send(64'h7FF, 5'd3);
        push_exp(32'h000011B7, 1'b0);
        push_exp(32'h8001819B, 1'b1);
        send(64'h800, 5'd3);
        push_exp(32'h123452B7, 1'b0);
        push_exp(32'h6782829B, 1'b1);
        send(64'h1234_5678, 5'd5);
        bus.req_valid = 1'b1;
        bus.req_imm   = 64'h7FFF_FFFF;
        bus.req_rd    = 5'd1;
        @(negedge clk);
        check("busy_req_ready", {63'd0, bus.req_ready}, 64'd0);
        push_exp(32'h800000B7, 1'b0);
        push_exp(32'hFFF0809B, 1'b1);
        send(64'h7FFF_FFFF, 5'd1);
        push_exp(32'h800000B7, 1'b0);
        push_exp(32'h0000809B, 1'b1);
        send(64'hFFFF_FFFF_8000_0000, 5'd1);
        drain();

        // 8-word sequence with a 3-cycle stall on word 3.
        for (int i = 0; i < 8; i++) push_exp(seq_a[i], i == 7);
        base = n_popped;
        send(64'h0000_0001_0000_0000, 5'd1);
        wait_pops(base + 2);
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_instr", {32'd0, bus.instr}, 64'h00B09093);
            check("stall_valid", {63'd0, bus.instr_valid}, 64'd1);
        end
        @(posedge clk);
        #1;
        bus.instr_ready = 1'b1;
        drain();

        for (int i = 0; i < 8; i++) push_exp(seq_b[i], i == 7);
        send(64'h0000_0001_0000_0C03, 5'd1);
        drain();

        // Reset while word 4 is presented.
        for (int i = 0; i < 8; i++) push_exp(seq_a[i], i == 7);
        base = n_popped;
        send(64'h0000_0001_0000_0000, 5'd1);
        wait_pops(base + 3);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q_exp.delete();
        check("mid_rst_valid", {63'd0, bus.instr_valid}, 64'd0);
        check("mid_rst_ready", {63'd0, bus.req_ready},   64'd1);
        check("mid_rst_instr", {32'd0, bus.instr},       64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mid_rst_quiet", {63'd0, bus.instr_valid}, 64'd0);
        push_exp(32'h00500093, 1'b1);
        send(64'd5, 5'd1);
        drain();

        check("final_queue", 64'(q_exp.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
